// File: rtl/axil_switch_rd.sv
// AXI4-Lite read-channel switch: one master, NUMBER_SLAVE slaves, one outstanding read.
// Illegal addresses are answered locally with DECERR and never reach a slave.
module axil_switch_rd #(
  parameter int NUMBER_SLAVE   = 4,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32
) (
  input  logic                                   aclk,
  input  logic                                   areset,
  input  logic [NUMBER_SLAVE-1:0]                slv_select,
  input  logic                                   addr_illegal,
  input  logic [AXI_ADDR_WIDTH-1:0]              m_axil_araddr,
  input  logic                                   m_axil_arvalid,
  output logic                                   m_axil_arready,
  output logic [AXI_DATA_WIDTH-1:0]              m_axil_rdata,
  output logic [1:0]                             m_axil_rresp,
  output logic                                   m_axil_rvalid,
  input  logic                                   m_axil_rready,
  output logic [AXI_ADDR_WIDTH-1:0]              s_axil_araddr,
  output logic [NUMBER_SLAVE-1:0]                s_axil_arvalid,
  input  logic [NUMBER_SLAVE-1:0]                s_axil_arready,
  input  logic [NUMBER_SLAVE*AXI_DATA_WIDTH-1:0] s_axil_rdata,
  input  logic [NUMBER_SLAVE*2-1:0]              s_axil_rresp,
  input  logic [NUMBER_SLAVE-1:0]                s_axil_rvalid,
  output logic [NUMBER_SLAVE-1:0]                s_axil_rready
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;

  localparam logic [1:0] RESP_DECERR = 2'b11;

  logic [1:0]                state;
  logic [1:0]                state_nxt;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [NUMBER_SLAVE-1:0]   sel_q;
  logic [NUMBER_SLAVE-1:0]   sel_first;
  logic                      ar_hs;
  logic                      sel_arready;
  logic                      sel_rvalid;
  logic [AXI_DATA_WIDTH-1:0] sel_rdata;
  logic [1:0]                sel_rresp;

  assign ar_hs = m_axil_arvalid && (state == IDLE);

  // Lowest set bit wins when the decoder reports overlapping hits.
  always_comb begin
    sel_first = '0;
    for (int i = NUMBER_SLAVE - 1; i >= 0; i--) begin
      if (slv_select[i]) begin
        sel_first    = '0;
        sel_first[i] = 1'b1;
      end
    end
  end

  always_comb begin
    sel_rdata = '0;
    sel_rresp = '0;
    for (int i = 0; i < NUMBER_SLAVE; i++) begin
      if (sel_q[i]) begin
        sel_rdata = sel_rdata | s_axil_rdata[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
        sel_rresp = sel_rresp | s_axil_rresp[i*2 +: 2];
      end
    end
  end

  assign sel_arready = |(s_axil_arready & sel_q);
  assign sel_rvalid  = |(s_axil_rvalid & sel_q);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        // A request with no decoder hit would otherwise wait forever in ADDR.
        if (ar_hs) begin
          if (addr_illegal || (sel_first == '0)) state_nxt = ERR;
          else                                   state_nxt = ADDR;
        end
      end
      ADDR:    if (sel_arready) state_nxt = DATA;
      DATA:    if (sel_rvalid && m_axil_rready) state_nxt = IDLE;
      ERR:     if (m_axil_rready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state  <= IDLE;
      addr_q <= '0;
      sel_q  <= '0;
    end else begin
      state <= state_nxt;
      if (ar_hs) begin
        addr_q <= m_axil_araddr;
        sel_q  <= sel_first;
      end
    end
  end

  assign s_axil_araddr = addr_q;

  // Everything downstream is gated by state, so a reset silences all valids at once.
  always_comb begin
    m_axil_arready = (state == IDLE);
    m_axil_rvalid  = 1'b0;
    m_axil_rdata   = '0;
    m_axil_rresp   = '0;
    s_axil_arvalid = '0;
    s_axil_rready  = '0;
    case (state)
      ADDR: s_axil_arvalid = sel_q;
      DATA: begin
        m_axil_rvalid = sel_rvalid;
        m_axil_rdata  = sel_rdata;
        m_axil_rresp  = sel_rresp;
        s_axil_rready = sel_q & {NUMBER_SLAVE{m_axil_rready}};
      end
      ERR: begin
        m_axil_rvalid = 1'b1;
        m_axil_rresp  = RESP_DECERR;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axil_switch_rd.sv
// Directed bench for axil_switch_rd: per-cycle vector table plus hand-written
// reset-in-DATA and recovery sequence.
module tb_axil_switch_rd;

  localparam logic [31:0] D0 = 32'h0000_1111;
  localparam logic [31:0] D1 = 32'hCAFE_0001;
  localparam logic [31:0] D2 = 32'hDEAD_BEEF;
  localparam logic [31:0] D3 = 32'h3333_3333;
  localparam logic [31:0] A0 = 32'h0000_0100;
  localparam logic [31:0] A1 = 32'h1000_0040;
  localparam logic [31:0] A2 = 32'h2000_0010;
  localparam logic [31:0] A3 = 32'h3000_0008;
  localparam logic [31:0] AE = 32'hF000_0000;

  logic        aclk = 1'b0;
  logic        areset;
  logic [3:0]  slv_select;
  logic        addr_illegal;
  logic [31:0] m_axil_araddr;
  logic        m_axil_arvalid;
  logic        m_axil_arready;
  logic [31:0] m_axil_rdata;
  logic [1:0]  m_axil_rresp;
  logic        m_axil_rvalid;
  logic        m_axil_rready;
  logic [31:0] s_axil_araddr;
  logic [3:0]  s_axil_arvalid;
  logic [3:0]  s_axil_arready;
  logic [127:0] s_axil_rdata;
  logic [7:0]  s_axil_rresp;
  logic [3:0]  s_axil_rvalid;
  logic [3:0]  s_axil_rready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 aclk = ~aclk;

  axil_switch_rd #(
    .NUMBER_SLAVE  (4),
    .AXI_ADDR_WIDTH(32),
    .AXI_DATA_WIDTH(32)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .slv_select    (slv_select),
    .addr_illegal  (addr_illegal),
    .m_axil_araddr (m_axil_araddr),
    .m_axil_arvalid(m_axil_arvalid),
    .m_axil_arready(m_axil_arready),
    .m_axil_rdata  (m_axil_rdata),
    .m_axil_rresp  (m_axil_rresp),
    .m_axil_rvalid (m_axil_rvalid),
    .m_axil_rready (m_axil_rready),
    .s_axil_araddr (s_axil_araddr),
    .s_axil_arvalid(s_axil_arvalid),
    .s_axil_arready(s_axil_arready),
    .s_axil_rdata  (s_axil_rdata),
    .s_axil_rresp  (s_axil_rresp),
    .s_axil_rvalid (s_axil_rvalid),
    .s_axil_rready (s_axil_rready)
  );

  typedef struct {
    logic        rst;
    logic        arv;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic        ill;
    logic [3:0]  sarr;
    logic [3:0]  srv;
    logic        rr;
    logic        e_arr;
    logic [3:0]  e_sarv;
    logic [3:0]  e_srr;
    logic        e_rv;
    logic [31:0] e_rdata;
    logic [1:0]  e_rresp;
    logic [31:0] e_saddr;
  } vec_t;

  vec_t vq[$];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    areset         = v.rst;
    m_axil_arvalid = v.arv;
    m_axil_araddr  = v.addr;
    slv_select     = v.sel;
    addr_illegal   = v.ill;
    s_axil_arready = v.sarr;
    s_axil_rvalid  = v.srv;
    m_axil_rready  = v.rr;
  endtask

  task automatic check_all(input string tag, input vec_t v);
    check_output({tag, " arready"},   32'(m_axil_arready), 32'(v.e_arr));
    check_output({tag, " s_arvalid"}, 32'(s_axil_arvalid), 32'(v.e_sarv));
    check_output({tag, " s_rready"},  32'(s_axil_rready),  32'(v.e_srr));
    check_output({tag, " rvalid"},    32'(m_axil_rvalid),  32'(v.e_rv));
    check_output({tag, " rdata"},     m_axil_rdata,        v.e_rdata);
    check_output({tag, " rresp"},     32'(m_axil_rresp),   32'(v.e_rresp));
    check_output({tag, " s_araddr"},  s_axil_araddr,       v.e_saddr);
  endtask

  initial begin
    vec_t v;
    bit   got_rv;
    s_axil_rdata = {D3, D2, D1, D0};
    s_axil_rresp = {2'b00, 2'b00, 2'b01, 2'b00};
    areset = 1'b1;
    m_axil_arvalid = 1'b0; m_axil_araddr = '0; slv_select = '0; addr_illegal = 1'b0;
    s_axil_arready = '0; s_axil_rvalid = '0; m_axil_rready = 1'b0;

    //             rst arv addr          sel      ill sarr     srv      rr   arr sarv     srr      rv rdata  resp   saddr
    vq.push_back('{1'b1,1'b1,32'h5555_0000,4'b0001,1'b0,4'b0000,4'b0000,1'b0, 1'b1,4'b0000,4'b0000,1'b0,32'h0,2'b00,32'h0});
    // legal read to slave 2, minimum latency
    vq.push_back('{1'b0,1'b1,A2,4'b0100,1'b0,4'b1111,4'b0000,1'b1, 1'b1,4'b0000,4'b0000,1'b0,32'h0,2'b00,32'h0});
    vq.push_back('{1'b0,1'b0,32'h0,4'b0000,1'b0,4'b1111,4'b0100,1'b1, 1'b0,4'b0100,4'b0000,1'b0,32'h0,2'b00,A2});
    vq.push_back('{1'b0,1'b0,32'h0,4'b0000,1'b0,4'b0000,4'b0100,1'b1, 1'b0,4'b0000,4'b0100,1'b1,D2,2'b00,A2});
    vq.push_back('{1'b0,1'b0,32'h0,4'b0000,1'b0,4'b0000,4'b0000,1'b1, 1'b1,4'b0000,4'b0000,1'b0,32'h0,2'b00,A2});
    // illegal address: DECERR held through 5 cycles of back-pressure
    vq.push_back('{1'b0,1'b1,AE,4'b0000,1'b1,4'b1111,4'b0000,1'b0, 1'b1,4'b0000,4'b0000,1'b0,32'h0,2'b00,A2});
    for (int k = 0; k < 5; k++)
      vq.push_back('{1'b0,1'b0,32'h0,4'b0000,1'b0,4'b1111,4'b0000,1'b0, 1'b0,4'b0000,4'b0000,1'b1,32'h0,2'b11,AE});
    vq.push_back('{1'b0,1'b0,32'h0,4'b0000,1'b0,4'b1111,4'b0000,1'b1, 1'b0,4'b0000,4'b0000,1'b1,32'h0,2'b11,AE});
    vq.push_back('{1'b0,1'b0,32'h0,4'b0000,1'b0,4'b0000,4'b0000,1'b0, 1'b1,4'b0000,4'b0000,1'b0,32'h0,2'b00,AE});
    // slave 0 with delayed arready, spurious rvalid from slave 3
    vq.push_back('{1'b0,1'b1,A0,4'b0001,1'b0,4'b0000,4'b0000,1'b1, 1'b1,4'b0000,4'b0000,1'b0,32'h0,2'b00,AE});
    vq.push_back('{1'b0,1'b0,32'h0,4'b0000,1'b0,4'b0000,4'b1000,1'b1, 1'b0,4'b0001,4'b0000,1'b0,32'h0,2'b00,A0});
    vq.push_back('{1'b0,1'b0,32'h0,4'b0000,1'b0,4'b1110,4'b1000,1'b1, 1'b0,4'b0001,4'b0000,1'b0,32'h0,2'b00,A0});
    vq.push_back('{1'b0,1'b0,32'h0,4'b0000,1'b0,4'b0000,4'b0000,1'b1, 1'b0,4'b0001,4'b0000,1'b0,32'h0,2'b00,A0});
    vq.push_back('{1'b0,1'b0,32'h0,4'b0000,1'b0,4'b0001,4'b0000,1'b1, 1'b0,4'b0001,4'b0000,1'b0,32'h0,2'b00,A0});
    vq.push_back('{1'b0,1'b0,32'h0,4'b0000,1'b0,4'b0000,4'b1000,1'b1, 1'b0,4'b0000,4'b0001,1'b0,D0,2'b00,A0});
    vq.push_back('{1'b0,1'b0,32'h0,4'b0000,1'b0,4'b0000,4'b1001,1'b1, 1'b0,4'b0000,4'b0001,1'b1,D0,2'b00,A0});
    vq.push_back('{1'b0,1'b0,32'h0,4'b0000,1'b0,4'b0000,4'b0000,1'b1, 1'b1,4'b0000,4'b0000,1'b0,32'h0,2'b00,A0});
    // multi-hot select resolves to slave 1, then master back-pressure
    vq.push_back('{1'b0,1'b1,A1,4'b0110,1'b0,4'b1111,4'b0000,1'b0, 1'b1,4'b0000,4'b0000,1'b0,32'h0,2'b00,A0});
    vq.push_back('{1'b0,1'b0,32'h0,4'b0000,1'b0,4'b1111,4'b0000,1'b0, 1'b0,4'b0010,4'b0000,1'b0,32'h0,2'b00,A1});
    for (int k = 0; k < 4; k++)
      vq.push_back('{1'b0,1'b0,32'h0,4'b0000,1'b0,4'b0000,4'b0010,1'b0, 1'b0,4'b0000,4'b0000,1'b1,D1,2'b01,A1});
    vq.push_back('{1'b0,1'b0,32'h0,4'b0000,1'b0,4'b0000,4'b0010,1'b1, 1'b0,4'b0000,4'b0010,1'b1,D1,2'b01,A1});
    vq.push_back('{1'b0,1'b0,32'h0,4'b0000,1'b0,4'b0000,4'b0010,1'b1, 1'b1,4'b0000,4'b0000,1'b0,32'h0,2'b00,A1});

    apply_stimulus(vq[0]);
    #3;
    check_all("v0", vq[0]);
    for (int i = 1; i < vq.size(); i++) begin
      @(posedge aclk); #1;
      apply_stimulus(vq[i]);
      #3;
      check_all($sformatf("v%0d", i), vq[i]);
    end

    // reset while waiting in DATA for slave 3
    @(posedge aclk); #1;
    m_axil_arvalid = 1'b1; m_axil_araddr = A3; slv_select = 4'b1000;
    s_axil_arready = 4'b0000; s_axil_rvalid = 4'b0000; m_axil_rready = 1'b1;
    @(posedge aclk); #1;
    m_axil_arvalid = 1'b0; slv_select = 4'b0000; s_axil_arready = 4'b1000;
    @(posedge aclk); #1;
    s_axil_arready = 4'b0000;
    #1;
    check_output("data s_rready", 32'(s_axil_rready), 32'(4'b1000));
    areset = 1'b1;
    s_axil_rvalid = 4'b1000;
    #1;
    v = '{1'b1,1'b0,32'h0,4'b0000,1'b0,4'b0000,4'b1000,1'b1, 1'b1,4'b0000,4'b0000,1'b0,32'h0,2'b00,32'h0};
    check_all("rst_now", v);
    @(posedge aclk); #1;
    check_all("rst_hold", v);
    areset = 1'b0;
    s_axil_rvalid = 4'b0000;

    // a fresh read to slave 3 after reset completes normally
    @(posedge aclk); #1;
    m_axil_arvalid = 1'b1; m_axil_araddr = A3; slv_select = 4'b1000;
    s_axil_arready = 4'b1000; s_axil_rvalid = 4'b1000; m_axil_rready = 1'b1;
    #1;
    check_output("post arready", 32'(m_axil_arready), 32'd1);
    check_output("post rvalid idle", 32'(m_axil_rvalid), 32'd0);
    @(posedge aclk); #1;
    m_axil_arvalid = 1'b0; slv_select = 4'b0000;
    #1;
    check_output("post s_arvalid", 32'(s_axil_arvalid), 32'(4'b1000));
    check_output("post s_araddr", s_axil_araddr, A3);
    got_rv = 1'b0;
    for (int c = 0; c < 8 && !got_rv; c++) begin
      @(posedge aclk); #2;
      if (m_axil_rvalid) got_rv = 1'b1;
    end
    check_output("post rvalid seen", 32'(got_rv), 32'd1);
    check_output("post rdata", m_axil_rdata, D3);
    check_output("post rresp", 32'(m_axil_rresp), 32'd0);
    @(posedge aclk); #2;
    check_output("post back idle", 32'(m_axil_arready), 32'd1);
    check_output("post rvalid clr", 32'(m_axil_rvalid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
